// File: rtl/reset_seq.sv
// Multi-domain reset sequencer: holds all domain resets while the PLL is
// unlocked or software requests reset, then releases them in index order.
module reset_seq #(
    parameter int NCH   = 4,
    parameter int DELAY = 8,
    parameter int FILT  = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           locked,
    input  logic           swrst,
    output logic [NCH-1:0] rst_o,
    output logic           ready,
    output logic [1:0]     state_o,
    output logic [7:0]     lock_loss
);

    localparam int HW = $clog2(DELAY + 1);
    localparam int LW = $clog2(FILT + 1);
    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [HW-1:0] HMAX  = HW'(DELAY);
    localparam logic [HW-1:0] SLAST = HW'(DELAY - 1);
    localparam logic [LW-1:0] LMAX  = LW'(FILT);
    localparam logic [IW-1:0] ILAST = IW'(NCH - 1);

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } state_t;

    state_t         state, state_n;
    logic [HW-1:0]  hold_cnt, hold_n;
    logic [HW-1:0]  stage_cnt, stage_n;
    logic [LW-1:0]  lock_cnt, lock_n;
    logic [IW-1:0]  idx, idx_n;
    logic [NCH-1:0] rst_n;
    logic           ready_n;
    logic [7:0]     loss_n;

    assign state_o = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HOLD;
            hold_cnt  <= '0;
            stage_cnt <= '0;
            lock_cnt  <= '0;
            idx       <= '0;
            rst_o     <= '1;
            ready     <= 1'b0;
            lock_loss <= 8'd0;
        end else begin
            state     <= state_n;
            hold_cnt  <= hold_n;
            stage_cnt <= stage_n;
            lock_cnt  <= lock_n;
            idx       <= idx_n;
            rst_o     <= rst_n;
            ready     <= ready_n;
            lock_loss <= loss_n;
        end
    end

    always_comb begin
        state_n = state;
        hold_n  = hold_cnt;
        stage_n = stage_cnt;
        lock_n  = lock_cnt;
        idx_n   = idx;
        rst_n   = rst_o;
        ready_n = ready;
        loss_n  = lock_loss;

        case (state)
            HOLD: begin
                rst_n   = '1;
                ready_n = 1'b0;
                if (swrst)
                    hold_n = '0;
                else if (hold_cnt != HMAX)
                    hold_n = hold_cnt + 1'b1;
                if (!locked)
                    lock_n = '0;
                else if (lock_cnt != LMAX)
                    lock_n = lock_cnt + 1'b1;
                if (hold_cnt == HMAX && lock_cnt == LMAX && !swrst) begin
                    state_n = RELEASE;
                    stage_n = '0;
                    idx_n   = '0;
                end
            end
            RELEASE, RUN: begin
                if (!locked || swrst) begin
                    state_n = HOLD;
                    rst_n   = '1;
                    ready_n = 1'b0;
                    hold_n  = '0;
                    stage_n = '0;
                    idx_n   = '0;
                    lock_n  = LW'(locked);
                    if (!locked && lock_loss != 8'hFF)
                        loss_n = lock_loss + 8'd1;
                end else if (state == RELEASE) begin
                    stage_n = stage_cnt + 1'b1;
                    if (stage_cnt == SLAST) begin
                        rst_n[idx] = 1'b0;
                        stage_n    = '0;
                        // idx parks on the last domain instead of wrapping
                        if (idx == ILAST) begin
                            state_n = RUN;
                            ready_n = 1'b1;
                        end else begin
                            idx_n = idx + 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_n = HOLD;
                rst_n   = '1;
                ready_n = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_reset_seq.sv
// Self-checking bench for reset_seq: fixed release-schedule table,
// hand-written corner sequences and randomized run against a timeline model.
module tb_reset_seq;

    localparam int NCH   = 4;
    localparam int DELAY = 8;
    localparam int FILT  = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           locked;
    logic           swrst;
    logic [NCH-1:0] rst_o;
    logic           ready;
    logic [1:0]     state_o;
    logic [7:0]     lock_loss;

    reset_seq #(.NCH(NCH), .DELAY(DELAY), .FILT(FILT)) dut (
        .clk       (clk),
        .rst       (rst),
        .locked    (locked),
        .swrst     (swrst),
        .rst_o     (rst_o),
        .ready     (ready),
        .state_o   (state_o),
        .lock_loss (lock_loss)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int edge_no = 0;

    // Timeline model: m_rel is cycles since release began (-1 while held),
    // m_hold is cycles since the last hold trigger, m_lock the locked run.
    int m_rel  = -1;
    int m_hold = 0;
    int m_lock = 0;
    int m_loss = 0;

    function automatic void model_edge(logic r, logic l, logic s);
        if (r) begin
            m_rel  = -1;
            m_hold = 0;
            m_lock = 0;
            m_loss = 0;
        end else if (m_rel < 0) begin
            if (m_hold >= DELAY && m_lock >= FILT && !s)
                m_rel = 0;
            m_hold = s ? 0 : m_hold + 1;
            m_lock = l ? m_lock + 1 : 0;
        end else if (!l || s) begin
            m_rel  = -1;
            m_hold = 0;
            m_lock = l ? 1 : 0;
            if (!l && m_loss < 255)
                m_loss = m_loss + 1;
        end else if (m_rel < NCH * DELAY) begin
            m_rel = m_rel + 1;
        end
    endfunction

    function automatic int m_released();
        if (m_rel < 0)
            return 0;
        return (m_rel / DELAY > NCH) ? NCH : m_rel / DELAY;
    endfunction

    task automatic check(string name, logic [NCH-1:0] er, logic ey,
                         logic [1:0] es, logic [7:0] el);
        n_chk++;
        if (rst_o !== er || ready !== ey || state_o !== es
            || lock_loss !== el) begin
            n_fail++;
            $display("FAIL %s: got rst_o=%h ready=%b state=%0d loss=%0d, want %h %b %0d %0d",
                     name, rst_o, ready, state_o, lock_loss, er, ey, es, el);
        end
    endtask

    task automatic step(logic r, logic l, logic s);
        logic [NCH-1:0] er;
        int             rel;
        rst    = r;
        locked = l;
        swrst  = s;
        @(posedge clk);
        model_edge(r, l, s);
        edge_no = r ? 0 : edge_no + 1;
        #1;
        rel = m_released();
        er  = '1;
        for (int i = 0; i < rel; i++)
            er[i] = 1'b0;
        check($sformatf("model@%0d", edge_no), er, rel == NCH,
              (m_rel < 0) ? 2'd0 : ((rel == NCH) ? 2'd2 : 2'd1),
              8'(m_loss));
    endtask

    typedef struct {
        int              edge_n;
        logic            locked;
        logic            swrst;
        logic [NCH-1:0]  rst_o;
        logic            ready;
        logic [1:0]      state;
        logic [7:0]      loss;
    } vec_t;

    vec_t vt[$];

    task automatic wait_ready(string name);
        int n = 0;
        while (!ready && n < 60) begin
            step(1'b0, 1'b1, 1'b0);
            n++;
        end
        if (!ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: ready still %b after %0d edges, want 1",
                     name, ready, n);
        end
    endtask

    initial begin
        vt.push_back('{  1, 1'b1, 1'b0, 4'hF, 1'b0, 2'd0, 8'd0});
        vt.push_back('{  8, 1'b1, 1'b0, 4'hF, 1'b0, 2'd0, 8'd0});
        vt.push_back('{  9, 1'b1, 1'b0, 4'hF, 1'b0, 2'd1, 8'd0});
        vt.push_back('{ 16, 1'b1, 1'b0, 4'hF, 1'b0, 2'd1, 8'd0});
        vt.push_back('{ 17, 1'b1, 1'b0, 4'hE, 1'b0, 2'd1, 8'd0});
        vt.push_back('{ 24, 1'b1, 1'b0, 4'hE, 1'b0, 2'd1, 8'd0});
        vt.push_back('{ 25, 1'b1, 1'b0, 4'hC, 1'b0, 2'd1, 8'd0});
        vt.push_back('{ 33, 1'b1, 1'b0, 4'h8, 1'b0, 2'd1, 8'd0});
        vt.push_back('{ 40, 1'b1, 1'b0, 4'h8, 1'b0, 2'd1, 8'd0});
        vt.push_back('{ 41, 1'b1, 1'b0, 4'h0, 1'b1, 2'd2, 8'd0});
        vt.push_back('{ 45, 1'b1, 1'b0, 4'h0, 1'b1, 2'd2, 8'd0});
        vt.push_back('{ 46, 1'b0, 1'b0, 4'hF, 1'b0, 2'd0, 8'd1});
        vt.push_back('{ 54, 1'b1, 1'b0, 4'hF, 1'b0, 2'd0, 8'd1});
        vt.push_back('{ 55, 1'b1, 1'b0, 4'hF, 1'b0, 2'd1, 8'd1});
        vt.push_back('{ 62, 1'b1, 1'b0, 4'hF, 1'b0, 2'd1, 8'd1});
        vt.push_back('{ 63, 1'b1, 1'b0, 4'hE, 1'b0, 2'd1, 8'd1});
        vt.push_back('{ 71, 1'b1, 1'b0, 4'hC, 1'b0, 2'd1, 8'd1});
        vt.push_back('{ 73, 1'b1, 1'b0, 4'hC, 1'b0, 2'd1, 8'd1});
        vt.push_back('{ 74, 1'b1, 1'b1, 4'hF, 1'b0, 2'd0, 8'd1});
        vt.push_back('{ 82, 1'b1, 1'b0, 4'hF, 1'b0, 2'd0, 8'd1});
        vt.push_back('{ 83, 1'b1, 1'b0, 4'hF, 1'b0, 2'd1, 8'd1});
        vt.push_back('{ 90, 1'b1, 1'b0, 4'hF, 1'b0, 2'd1, 8'd1});
        vt.push_back('{ 91, 1'b1, 1'b0, 4'hE, 1'b0, 2'd1, 8'd1});
        vt.push_back('{114, 1'b1, 1'b0, 4'h8, 1'b0, 2'd1, 8'd1});
        vt.push_back('{115, 1'b1, 1'b0, 4'h0, 1'b1, 2'd2, 8'd1});

        rst = 1'b1;
        locked = 1'b1;
        swrst = 1'b0;

        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, 1'b0);
        check("reset_state", 4'hF, 1'b0, 2'd0, 8'd0);

        foreach (vt[i]) begin
            while (edge_no < vt[i].edge_n)
                step(1'b0, vt[i].locked, vt[i].swrst);
            check($sformatf("table@%0d", vt[i].edge_n), vt[i].rst_o,
                  vt[i].ready, vt[i].state, vt[i].loss);
        end

        // late lock: locked first sampled high at edge 20
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        while (edge_no < 19)
            step(1'b0, 1'b0, 1'b0);
        while (edge_no < 23)
            step(1'b0, 1'b1, 1'b0);
        check("late_lock@23", 4'hF, 1'b0, 2'd0, 8'd0);
        step(1'b0, 1'b1, 1'b0);
        check("late_lock@24", 4'hF, 1'b0, 2'd1, 8'd0);
        while (edge_no < 31)
            step(1'b0, 1'b1, 1'b0);
        check("late_lock@31", 4'hF, 1'b0, 2'd1, 8'd0);
        step(1'b0, 1'b1, 1'b0);
        check("late_lock@32", 4'hE, 1'b0, 2'd1, 8'd0);

        // lock_loss saturation over 300 aborts from RUN
        wait_ready("sat_start");
        for (int k = 0; k < 300; k++) begin
            step(1'b0, 1'b0, 1'b0);
            wait_ready($sformatf("sat_iter%0d", k));
        end
        check("loss_saturated", 4'h0, 1'b1, 2'd2, 8'd255);
        step(1'b1, 1'b1, 1'b0);
        check("rst_clears_loss", 4'hF, 1'b0, 2'd0, 8'd0);

        // rst in the middle of RELEASE
        while (edge_no < 29)
            step(1'b0, 1'b1, 1'b0);
        check("pre_mid_rst@29", 4'hC, 1'b0, 2'd1, 8'd0);
        step(1'b1, 1'b1, 1'b0);
        check("mid_release_rst", 4'hF, 1'b0, 2'd0, 8'd0);

        for (int k = 0; k < 4000; k++)
            step($urandom_range(0, 399) == 0,
                 $urandom_range(0, 119) != 0,
                 $urandom_range(0, 199) == 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
